// File: rtl/alu_seq.sv
// alu_seq: registered ALU with NZCV flags and a start/busy/done handshake.
// Single-cycle ops finish one cycle after start. MUL/DIVU/REMU run iteratively
// over WIDTH cycles when ALU_SEQ_MULDIV_EN is defined. Without the macro those
// opcodes complete in one cycle with a zero result and IllegalOp raised.
module alu_seq #(
   parameter  int WIDTH = 16,
   localparam int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic [3:0]       ALUControl,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             Negative,
   output logic             Carry,
   output logic             Overflow,
   output logic             busy,
   output logic             done,
   output logic             IllegalOp
);

   localparam logic [3:0] OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
                          OP_XOR  = 4'h4, OP_SLT  = 4'h5, OP_SLTU = 4'h6,
                          OP_SLL  = 4'h7, OP_SRL  = 4'h8, OP_SRA  = 4'h9,
                          OP_MUL  = 4'hA, OP_DIVU = 4'hB, OP_REMU = 4'hC;

`ifdef ALU_SEQ_MULDIV_EN
   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIN = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, FIN = 2'd2} state_t;
`endif

   state_t           state, state_n;
   logic             accept, go_iter;
   logic [WIDTH:0]   sum, dif;
   logic [WIDTH-1:0] res_c;
   logic             c_c, v_c;
   logic [SHW-1:0]   sh;

   assign sh     = SrcB[SHW-1:0];
   assign accept = start && (state == IDLE || state == FIN);

`ifdef ALU_SEQ_MULDIV_EN
   logic             is_md, div0, ge;
   logic [WIDTH-1:0] acc, x, y, acc_n, x_n, y_n, mul_acc, it_res;
   logic [WIDTH:0]   r_sh, d_try;
   logic [3:0]       op_q;
   logic [SHW-1:0]   cnt;

   assign is_md   = (ALUControl == OP_MUL) || (ALUControl == OP_DIVU) || (ALUControl == OP_REMU);
   // divide by zero short-circuits to the single-cycle path
   assign div0    = (ALUControl == OP_DIVU || ALUControl == OP_REMU) && (SrcB == '0);
   assign go_iter = is_md && !div0;
`else
   logic ill_c, ill_q;
   assign go_iter = 1'b0;
`endif

   // single-cycle result and flags straight from the inputs
   always_comb begin
      sum   = {1'b0, SrcA} + {1'b0, SrcB};
      dif   = {1'b0, SrcA} - {1'b0, SrcB};
      res_c = '0;
      c_c   = 1'b0;
      v_c   = 1'b0;
`ifndef ALU_SEQ_MULDIV_EN
      ill_c = 1'b0;
`endif
      case (ALUControl)
         OP_SUB: begin
            res_c = dif[WIDTH-1:0];
            c_c   = ~dif[WIDTH];
            v_c   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (dif[WIDTH-1] != SrcA[WIDTH-1]);
         end
         OP_AND:  res_c = SrcA & SrcB;
         OP_OR:   res_c = SrcA | SrcB;
         OP_XOR:  res_c = SrcA ^ SrcB;
         OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
         OP_SLL:  res_c = SrcA << sh;
         OP_SRL:  res_c = SrcA >> sh;
         OP_SRA:  res_c = $signed(SrcA) >>> sh;
`ifdef ALU_SEQ_MULDIV_EN
         OP_MUL:  res_c = '0;
         OP_DIVU: res_c = '1;
         OP_REMU: res_c = SrcA;
`else
         OP_MUL, OP_DIVU, OP_REMU: ill_c = 1'b1;
`endif
         default: begin   // ADD, and 1101-1111 alias to ADD
            res_c = sum[WIDTH-1:0];
            c_c   = sum[WIDTH];
            v_c   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
         end
      endcase
   end

`ifdef ALU_SEQ_MULDIV_EN
   // one shift-add (MUL) or restoring-subtract (DIVU/REMU) step
   always_comb begin
      mul_acc = acc + (y[0] ? x : '0);
      r_sh    = {acc, x[WIDTH-1]};
      d_try   = r_sh - {1'b0, y};
      ge      = ~d_try[WIDTH];
      if (op_q == OP_MUL) begin
         acc_n = mul_acc;
         x_n   = x << 1;
         y_n   = y >> 1;
      end else begin
         acc_n = ge ? d_try[WIDTH-1:0] : r_sh[WIDTH-1:0];
         x_n   = {x[WIDTH-2:0], ge};
         y_n   = y;
      end
      case (op_q)
         OP_MUL:  it_res = mul_acc;
         OP_DIVU: it_res = x_n;
         default: it_res = acc_n;
      endcase
   end
`endif

   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // next-state logic
   always_comb begin
      state_n = IDLE;
      case (state)
`ifdef ALU_SEQ_MULDIV_EN
         ITER: state_n = (cnt == '0) ? FIN : ITER;
         IDLE, FIN: if (start) state_n = go_iter ? ITER : FIN;
`else
         IDLE, FIN: if (start) state_n = FIN;
`endif
         default: state_n = IDLE;
      endcase
   end

   // handshake outputs decoded from state
   always_comb begin
`ifdef ALU_SEQ_MULDIV_EN
      busy      = (state == ITER);
      IllegalOp = 1'b0;
`else
      busy      = 1'b0;
      IllegalOp = (state == FIN) && ill_q;
`endif
      done      = (state == FIN);
   end

   // result/flag registers and iterative datapath
   always_ff @(posedge clk) begin
      if (reset) begin
         ALUResult <= '0;
         Zero      <= 1'b0;
         Negative  <= 1'b0;
         Carry     <= 1'b0;
         Overflow  <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
         acc  <= '0;
         x    <= '0;
         y    <= '0;
         op_q <= '0;
         cnt  <= '0;
`else
         ill_q <= 1'b0;
`endif
      end else if (accept && !go_iter) begin
         ALUResult <= res_c;
         Zero      <= (res_c == '0);
         Negative  <= res_c[WIDTH-1];
         Carry     <= c_c;
         Overflow  <= v_c;
`ifndef ALU_SEQ_MULDIV_EN
         ill_q     <= ill_c;
`endif
      end
`ifdef ALU_SEQ_MULDIV_EN
      else if (accept) begin
         acc  <= '0;
         x    <= SrcA;
         y    <= SrcB;
         op_q <= ALUControl;
         cnt  <= SHW'(WIDTH-1);
      end else if (state == ITER) begin
         acc <= acc_n;
         x   <= x_n;
         y   <= y_n;
         cnt <= cnt - 1'b1;
         if (cnt == '0) begin
            ALUResult <= it_res;
            Zero      <= (it_res == '0);
            Negative  <= it_res[WIDTH-1];
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
         end
      end
`endif
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq; follows ALU_SEQ_MULDIV_EN for the mul/div section.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [15:0] SrcA, SrcB, ALUResult;
   logic [3:0]  ALUControl;
   logic        Zero, Negative, Carry, Overflow, busy, done, IllegalOp;
   int          n_chk = 0;
   int          n_fail = 0;
   int          lat;
   logic        saw_done;

   alu_seq #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .start(start), .SrcA(SrcA), .SrcB(SrcB),
      .ALUControl(ALUControl), .ALUResult(ALUResult), .Zero(Zero),
      .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
      .busy(busy), .done(done), .IllegalOp(IllegalOp)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_flags(input string tag, input logic z, input logic n, input logic c, input logic v);
      chk({tag, " flags"}, {28'd0, Zero, Negative, Carry, Overflow}, {28'd0, z, n, c, v});
   endtask

   // issue one op and wait (bounded) for done; lat = cycles from start to done
   task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int l);
      ALUControl = op; SrcA = a; SrcB = b; start = 1'b1;
      step();
      start = 1'b0;
      l = 1;
      while (done !== 1'b1 && l < 40) begin
         step();
         l++;
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; SrcA = '0; SrcB = '0; ALUControl = '0;
      step(); step();
      reset = 1'b0;
      step();
      chk("reset result", {16'd0, ALUResult}, 32'h0);
      chk_flags("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset busy/done/ill", {29'd0, busy, done, IllegalOp}, 32'h0);

      run_op(4'h0, 16'h7FFF, 16'h0001, lat);
      chk("add ovf lat", lat, 1);
      chk("add ovf res", {16'd0, ALUResult}, 32'h8000);
      chk_flags("add ovf", 1'b0, 1'b1, 1'b0, 1'b1);

      run_op(4'h1, 16'h0005, 16'h0005, lat);
      chk("sub zero lat", lat, 1);
      chk("sub zero res", {16'd0, ALUResult}, 32'h0);
      chk_flags("sub zero", 1'b1, 1'b0, 1'b1, 1'b0);

      run_op(4'h0, 16'hFFFF, 16'h0001, lat);
      chk("add carry res", {16'd0, ALUResult}, 32'h0);
      chk_flags("add carry", 1'b1, 1'b0, 1'b1, 1'b0);

      run_op(4'h1, 16'h0003, 16'h0005, lat);
      chk("sub borrow res", {16'd0, ALUResult}, 32'hFFFE);
      chk_flags("sub borrow", 1'b0, 1'b1, 1'b0, 1'b0);

      run_op(4'h7, 16'h0001, 16'h0013, lat);
      chk("sll upper bits ignored", {16'd0, ALUResult}, 32'h0008);

      run_op(4'hF, 16'h0002, 16'h0003, lat);
      chk("op F aliases add", {16'd0, ALUResult}, 32'h0005);

      run_op(4'h4, 16'h00FF, 16'h0F0F, lat);
      chk("xor res", {16'd0, ALUResult}, 32'h0FF0);
      chk_flags("xor", 1'b0, 1'b0, 1'b0, 1'b0);

      // back-to-back with start held high
      step();
      ALUControl = 4'h9; SrcA = 16'h8000; SrcB = 16'h0003; start = 1'b1;
      step();
      chk("b2b sra done", {31'd0, done}, 32'h1);
      chk("b2b sra res", {16'd0, ALUResult}, 32'hF000);
      chk_flags("b2b sra", 1'b0, 1'b1, 1'b0, 1'b0);
      ALUControl = 4'h5; SrcA = 16'hFFFF; SrcB = 16'h0001;
      step();
      chk("b2b slt done", {31'd0, done}, 32'h1);
      chk("b2b slt res", {16'd0, ALUResult}, 32'h0001);
      ALUControl = 4'h6;
      step();
      chk("b2b sltu done", {31'd0, done}, 32'h1);
      chk("b2b sltu res", {16'd0, ALUResult}, 32'h0000);
      chk_flags("b2b sltu", 1'b1, 1'b0, 1'b0, 1'b0);
      start = 1'b0;
      step();
      chk("idle done low", {31'd0, done}, 32'h0);
      chk("result held", {16'd0, ALUResult}, 32'h0000);

`ifdef ALU_SEQ_MULDIV_EN
      // MUL with an ignored ADD start during the iteration
      ALUControl = 4'hA; SrcA = 16'h0123; SrcB = 16'h0045; start = 1'b1;
      step();
      start = 1'b0;
      chk("mul busy c1", {30'd0, busy, done}, 32'h2);
      for (int i = 2; i <= 16; i++) begin
         if (i == 5) begin
            ALUControl = 4'h0; SrcA = 16'h0001; SrcB = 16'h0001; start = 1'b1;
         end
         step();
         start = 1'b0;
         chk("mul busy", {30'd0, busy, done}, 32'h2);
      end
      step();
      chk("mul done c17", {30'd0, busy, done}, 32'h1);
      chk("mul res", {16'd0, ALUResult}, 32'h4E6F);
      chk_flags("mul", 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      chk("mul no extra done", {31'd0, done}, 32'h0);

      run_op(4'hB, 16'd100, 16'd7, lat);
      chk("divu lat", lat, 17);
      chk("divu res", {16'd0, ALUResult}, 32'h000E);
      run_op(4'hC, 16'd100, 16'd7, lat);
      chk("remu lat", lat, 17);
      chk("remu res", {16'd0, ALUResult}, 32'h0002);
      run_op(4'hB, 16'h1234, 16'h0000, lat);
      chk("divu0 lat", lat, 1);
      chk("divu0 res", {16'd0, ALUResult}, 32'hFFFF);
      chk("divu0 ill", {31'd0, IllegalOp}, 32'h0);
      run_op(4'hC, 16'h1234, 16'h0000, lat);
      chk("remu0 lat", lat, 1);
      chk("remu0 res", {16'd0, ALUResult}, 32'h1234);

      // reset during a DIVU aborts it
      step();
      ALUControl = 4'hB; SrcA = 16'd100; SrcB = 16'd7; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst abort busy/done", {30'd0, busy, done}, 32'h0);
      chk("rst abort res", {16'd0, ALUResult}, 32'h0);
      chk("rst abort zero", {31'd0, Zero}, 32'h0);
      saw_done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (done === 1'b1) saw_done = 1'b1;
      end
      chk("no stale done", {31'd0, saw_done}, 32'h0);
      run_op(4'h0, 16'd2, 16'd3, lat);
      chk("add after rst lat", lat, 1);
      chk("add after rst res", {16'd0, ALUResult}, 32'h0005);
`else
      run_op(4'hA, 16'd3, 16'd4, lat);
      chk("mul off lat", lat, 1);
      chk("mul off ill", {31'd0, IllegalOp}, 32'h1);
      chk("mul off res", {16'd0, ALUResult}, 32'h0);
      chk_flags("mul off", 1'b1, 1'b0, 1'b0, 1'b0);
      run_op(4'h0, 16'd1, 16'd1, lat);
      chk("add after ill lat", lat, 1);
      chk("add after ill res", {16'd0, ALUResult}, 32'h0002);
      chk("add after ill ill", {31'd0, IllegalOp}, 32'h0);
      run_op(4'hC, 16'd100, 16'd7, lat);
      chk("remu off lat", lat, 1);
      chk("remu off ill", {31'd0, IllegalOp}, 32'h1);
      step();
      chk("ill pulse only", {30'd0, done, IllegalOp}, 32'h0);
      chk("busy never", {31'd0, busy}, 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
